// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu -- registered arithmetic/logic unit for the 8-bit computer datapath.
//
// Computes a function of two operands selected by a 4-bit opcode and
// registers the result together with zero/carry/negative/overflow flags.
// The compute path is purely combinational; every output changes only on
// a rising clk edge (or immediately on reset).
//
// Handshake: none. There is no valid/ready pair and no enable. Every rising
// edge with rst low captures the function of the op/data1/data2 values present
// at that edge. A result is therefore valid exactly one cycle after its inputs.
//
// Optional feature: define ALU_MUL_EN to enable op 0xD, the unsigned
// WIDTH x WIDTH multiply (low half to result, carry/overflow flag a non-zero
// high half). Without the macro no multiplier exists and 0xD acts as an
// unused opcode.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   op        in   4      operation select
//   data1     in   WIDTH  operand A
//   data2     in   WIDTH  operand B / shift amount source (low bits)
//   result    out  WIDTH  registered result
//   zero      out  1      registered, result == 0
//   carry     out  1      registered carry / no-borrow / shift-out
//   negative  out  1      registered copy of result MSB
//   overflow  out  1      registered signed overflow
// ----------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOR   = 4'h5;
  localparam logic [3:0] OP_SLL   = 4'h6;
  localparam logic [3:0] OP_SRL   = 4'h7;
  localparam logic [3:0] OP_SRA   = 4'h8;
  localparam logic [3:0] OP_SLT   = 4'h9;
  localparam logic [3:0] OP_PASSB = 4'hA;
  localparam logic [3:0] OP_INC   = 4'hB;
  localparam logic [3:0] OP_DEC   = 4'hC;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'hD;
`endif

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Shared arithmetic. INC/DEC reuse the add/subtract path with B forced to 1
  // so their carry/overflow rules are identical to ADD/SUB by construction.
  // --------------------------------------------------------------------------
  logic             incdec_sel;
  logic [WIDTH-1:0] arith_b;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic             add_ovf;
  logic             sub_ovf;

  assign incdec_sel = (op == OP_INC) || (op == OP_DEC);
  assign arith_b    = incdec_sel ? ONE : data2;
  assign sum_w      = {1'b0, data1} + {1'b0, arith_b};
  // Bit WIDTH of the difference is the borrow; carry is its complement.
  assign diff_w     = {1'b0, data1} - {1'b0, arith_b};

  assign add_ovf = (data1[MSB] == arith_b[MSB]) && (sum_w[MSB]  != data1[MSB]);
  assign sub_ovf = (data1[MSB] != arith_b[MSB]) && (diff_w[MSB] != data1[MSB]);

  // --------------------------------------------------------------------------
  // Shifts. Each operand is widened by one bit on the side the data leaves,
  // so the extra bit after shifting is exactly the last bit shifted out, and
  // it is naturally 0 for a zero shift amount. Upper bits of B are ignored.
  // --------------------------------------------------------------------------
  logic [SHW-1:0]        shamt;
  logic [WIDTH:0]        sll_w;
  logic [WIDTH:0]        srl_w;
  logic signed [WIDTH:0] sra_w;

  assign shamt = data2[SHW-1:0];
  assign sll_w = {1'b0, data1} << shamt;
  assign srl_w = {data1, 1'b0} >> shamt;
  assign sra_w = $signed({data1, 1'b0}) >>> shamt;

  logic slt_w;
  assign slt_w = $signed(data1) < $signed(data2);

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod_w;
  assign prod_w = {{WIDTH{1'b0}}, data1} * {{WIDTH{1'b0}}, data2};
`endif

  // --------------------------------------------------------------------------
  // Next-state selection
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;
  logic             overflow_d, overflow_q;
  logic             zero_d, zero_q;
  logic             negative_d, negative_q;

  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin
        result_d   = sum_w[WIDTH-1:0];
        carry_d    = sum_w[WIDTH];
        overflow_d = add_ovf;
      end
      OP_SUB, OP_DEC: begin
        result_d   = diff_w[WIDTH-1:0];
        carry_d    = ~diff_w[WIDTH];
        overflow_d = sub_ovf;
      end
      OP_AND:   result_d = data1 & data2;
      OP_OR:    result_d = data1 | data2;
      OP_XOR:   result_d = data1 ^ data2;
      OP_NOR:   result_d = ~(data1 | data2);
      OP_SLL: begin
        result_d = sll_w[WIDTH-1:0];
        carry_d  = sll_w[WIDTH];
      end
      OP_SRL: begin
        result_d = srl_w[WIDTH:1];
        carry_d  = srl_w[0];
      end
      OP_SRA: begin
        result_d = sra_w[WIDTH:1];
        carry_d  = sra_w[0];
      end
      OP_SLT:   result_d = {{(WIDTH-1){1'b0}}, slt_w};
      OP_PASSB: result_d = data2;
`ifdef ALU_MUL_EN
      OP_MUL: begin
        result_d   = prod_w[WIDTH-1:0];
        carry_d    = |prod_w[2*WIDTH-1:WIDTH];
        overflow_d = |prod_w[2*WIDTH-1:WIDTH];
      end
`endif
      // Unused opcodes keep the all-clear defaults.
      default: ;
    endcase
    zero_d     = (result_d == '0);
    negative_d = result_d[MSB];
  end

  // --------------------------------------------------------------------------
  // Output registers. Reset value reflects an all-zero result (zero flag set).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      zero_q     <= 1'b1;
      carry_q    <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign negative = negative_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// ----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu (WIDTH = 8).
// Directed steps followed by random operations; each expectation comes from
// an integer-arithmetic reference model and is queued until the result edge.
// ----------------------------------------------------------------------------
module tb_alu;

  logic       clk;
  logic       rst;
  logic [3:0] op;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       negative;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  // Packed expectation: {result[7:0], zero, carry, negative, overflow}
  logic [11:0] exp_q[$];

  alu #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .data1    (data1),
    .data2    (data2),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .negative (negative),
    .overflow (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [11:0] model(input logic [3:0] o,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    int ia = int'(a);
    int ib = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int n  = int'(b[2:0]);
    int r  = 0;
    logic c = 1'b0;
    logic v = 1'b0;
    logic [7:0] rv;
    case (o)
      4'h0: begin r = ia + ib; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'h1: begin r = ia - ib; c = (ia >= ib); v = (sa - sb > 127) || (sa - sb < -128); end
      4'h2: r = ia & ib;
      4'h3: r = ia | ib;
      4'h4: r = ia ^ ib;
      4'h5: r = ~(ia | ib);
      4'h6: begin r = ia << n; c = (n != 0) && (((ia >> (8 - n)) & 1) == 1); end
      4'h7: begin r = ia >> n; c = (n != 0) && (((ia >> (n - 1)) & 1) == 1); end
      4'h8: begin r = sa >>> n; c = (n != 0) && (((ia >> (n - 1)) & 1) == 1); end
      4'h9: r = (sa < sb) ? 1 : 0;
      4'hA: r = ib;
      4'hB: begin r = ia + 1; c = (r > 255); v = (sa + 1 > 127); end
      4'hC: begin r = ia - 1; c = (ia >= 1); v = (sa - 1 < -128); end
`ifdef ALU_MUL_EN
      4'hD: begin r = ia * ib; c = (r > 255); v = c; end
`endif
      default: r = 0;
    endcase
    rv = r[7:0];
    return {rv, (rv == 8'h00), c, rv[7], v};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [11:0] e);
    chk({tag, ".result"},   result,            e[11:4]);
    chk({tag, ".zero"},     {7'd0, zero},      {7'd0, e[3]});
    chk({tag, ".carry"},    {7'd0, carry},     {7'd0, e[2]});
    chk({tag, ".negative"}, {7'd0, negative},  {7'd0, e[1]});
    chk({tag, ".overflow"}, {7'd0, overflow},  {7'd0, e[0]});
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic [3:0] o,
                      input logic [7:0] a, input logic [7:0] b);
    logic [11:0] e;
    @(negedge clk);
    op = o; data1 = a; data2 = b;
    exp_q.push_back(model(o, a, b));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_outputs(tag, e);
    end
  endtask

  // Sanity anchor for hand-derived values from the test plan.
  task automatic step_known(input string tag, input logic [3:0] o,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] r, input logic c, input logic v);
    step(tag, o, a, b);
    chk({tag, ".known_r"}, result,        r);
    chk({tag, ".known_c"}, {7'd0, carry}, {7'd0, c});
    chk({tag, ".known_v"}, {7'd0, overflow}, {7'd0, v});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; op = 4'h0; data1 = 8'h00; data2 = 8'h00;
    #12;
    check_outputs("reset_init", {8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    // ADD
    step_known("add_01_fe", 4'h0, 8'h01, 8'hFE, 8'hFF, 1'b0, 1'b0);
    step_known("add_7f_01", 4'h0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    step_known("add_ff_01", 4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a cycle with result 0xFF held.
    step_known("pre_reset", 4'hA, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("reset_async", {8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    // SUB / SLT
    step_known("sub_05_05", 4'h1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0);
    step_known("sub_00_01", 4'h1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0);
    step_known("slt_fe_01", 4'h9, 8'hFE, 8'h01, 8'h01, 1'b0, 1'b0);
    step_known("slt_01_fe", 4'h9, 8'h01, 8'hFE, 8'h00, 1'b0, 1'b0);

    // Logic
    step_known("and", 4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    step_known("or",  4'h3, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0);
    step_known("xor", 4'h4, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0);
    step_known("nor", 4'h5, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0);

    // Shifts, including n = 0 via B = 0x08
    step_known("sll_1", 4'h6, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0);
    step_known("srl_1", 4'h7, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0);
    step_known("sra_1", 4'h8, 8'h81, 8'h01, 8'hC0, 1'b1, 1'b0);
    step_known("sll_0", 4'h6, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0);
    step_known("srl_0", 4'h7, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0);
    step_known("sra_0", 4'h8, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0);
    step_known("sll_7", 4'h6, 8'h03, 8'hFF, 8'h80, 1'b1, 1'b0);
    step_known("sra_7", 4'h8, 8'h80, 8'h07, 8'hFF, 1'b0, 1'b0);

    // INC / DEC wrap-around and overflow edges
    step_known("inc_ff", 4'hB, 8'hFF, 8'h55, 8'h00, 1'b1, 1'b0);
    step_known("inc_7f", 4'hB, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1);
    step_known("dec_00", 4'hC, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
    step_known("dec_80", 4'hC, 8'h80, 8'h00, 8'h7F, 1'b1, 1'b1);

    // MUL / unused opcodes
`ifdef ALU_MUL_EN
    step_known("mul_10_10", 4'hD, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1);
    step_known("mul_0f_11", 4'hD, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0);
`else
    step_known("mul_off", 4'hD, 8'h10, 8'h10, 8'h00, 1'b0, 1'b0);
`endif
    step_known("op_e", 4'hE, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    step_known("op_f", 4'hF, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0);

    // Random operations against the model
    for (int i = 0; i < 400; i++) begin
      step("rand", 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)));
    end

    // Back-to-back first capture after a reset released mid-stream
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step_known("post_reset_add", 4'h0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 8-bit registered arithmetic/logic unit for the datapath of the 8-bit computer.
- Takes two 8-bit operands and a 4-bit opcode and produces an 8-bit result plus status flags (zero, carry, negative, overflow).
- All outputs are registered with a one-cycle latency; the block is the sole arithmetic resource feeding the accumulator/flag logic.

Parameters:
- WIDTH, 8, operand/result width; all requirements below are written for the default 8.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- op  input  4  operation select (encoding below)
- data1  input  8  operand A
- data2  input  8  operand B / shift amount source
- result  output  8  registered operation result
- zero  output  1  registered; 1 when the result is 0x00
- carry  output  1  registered carry/borrow/shift-out flag
- negative  output  1  registered copy of result[7]
- overflow  output  1  registered signed-overflow flag

Behaviour:
- Reset: asserting rst immediately forces result=0x00, zero=1, carry=0, negative=0, overflow=0, whether or not a clock edge occurs. Reset mid-operation discards the in-flight result. The first capture happens on the first rising clk edge after rst deasserts.
- Latency: on every rising clk edge with rst low, the outputs register the function of the current op/data1/data2. There is no enable and no handshake. The result is valid exactly 1 cycle after its inputs.
- Opcodes and results (data1=A, data2=B):
  - 0x0 ADD: A+B; carry=bit 8 of the sum; overflow=(A[7]==B[7]) && (R[7]!=A[7]).
  - 0x1 SUB: A-B; carry=1 when A>=B unsigned (no borrow); overflow=(A[7]!=B[7]) && (R[7]!=A[7]).
  - 0x2 AND, 0x3 OR, 0x4 XOR, 0x5 NOR: bitwise; carry=0, overflow=0.
  - 0x6 SLL: A<<B[2:0]; carry=last bit shifted out (A[8-n]); 0 when n=0.
  - 0x7 SRL: logical right shift by B[2:0]; carry=A[n-1]; 0 when n=0.
  - 0x8 SRA: arithmetic right shift by B[2:0], sign-filled; carry as for SRL.
  - 0x9 SLT: 0x01 if A<B signed, else 0x00; carry=0, overflow=0.
  - 0xA PASSB: R=B. 0xB INC: A+1 with carry/overflow as ADD with B=1. 0xC DEC: A-1 with carry/overflow as SUB with B=1.
  - Shift and logic ops clear overflow. B[7:3] is ignored for shifts.
  - 0xD MUL: see Optional Feature.
  - 0xE, 0xF, and 0xD when MUL is absent: result=0x00, zero=1, carry=0, overflow=0, negative=0.
- Flags for all ops: zero=(R==0x00); negative=R[7].
- Wrap-around: ADD/INC/SUB/DEC results are modulo 256. Examples: 0xFF+0x01 gives 0x00, zero=1, carry=1. 0x00-0x01 gives 0xFF, carry=0, negative=1.
- Combinational compute path; no multicycle operations. Outputs hold their value only between clock edges.

Optional Feature:
- Macro ALU_MUL_EN.
- When defined, op 0xD computes the unsigned 8x8 product A*B: result=product[7:0]; carry=1 when product[15:8]!=0; overflow=carry; zero and negative derived from result. Latency stays 1 cycle.
- When undefined, no multiplier is synthesized and 0xD behaves as an unused opcode (result 0x00, zero=1, other flags 0).

Test Plan:
- Reset: assert rst asynchronously mid-cycle with prior result 0xFF -> result=0x00, zero=1, carry/negative/overflow=0 immediately, without a clock edge.
- ADD: op=0x0, A=0x01, B=0xFE -> next edge result=0xFF, zero=0, carry=0, negative=1, overflow=0. Then A=0x7F, B=0x01 -> 0x80, overflow=1. Then A=0xFF, B=0x01 -> 0x00, zero=1, carry=1.
- SUB/SLT: op=0x1, A=0x05, B=0x05 -> 0x00, zero=1, carry=1. Then A=0x00, B=0x01 -> 0xFF, carry=0. Then op=0x9, A=0xFE, B=0x01 -> 0x01.
- Logic: A=0xF0, B=0x3C -> AND 0x30, OR 0xFC, XOR 0xCC, NOR 0x03; carry=0 and overflow=0 for all four.
- Shifts: A=0x81, B=0x01 -> SLL 0x02 carry=1; SRL 0x40 carry=1; SRA 0xC0 carry=1. With B=0x08 (n=0) -> result 0x81, carry=0.
- MUL/unused: op=0xD, A=0x10, B=0x10 -> 0x00, carry=1, zero=1 with ALU_MUL_EN defined; 0x00, carry=0 without it. op=0xF -> 0x00, zero=1.
